// File: rtl/register_bank.sv
// ---------------------------------------------------------------------------
// register_bank
//   Architectural register storage: NUM_REGS x DATA_WIDTH registers with one
//   synchronous write port. All registers are presented in parallel on a flat
//   bus for the downstream read-port multiplexers. A scoreboard mask records
//   which registers have been written since reset, together with a saturating
//   count of distinct registers written.
//
// Ports
//   Clk          in   1                    clock, all state updates on rising edge
//   Reset        in   1                    synchronous, active-low reset
//   WrEn         in   1                    write strobe
//   WrAddr       in   ADDR_WIDTH           destination register index
//   WrData       in   DATA_WIDTH           write data
//   RegsOut      out  NUM_REGS*DATA_WIDTH  register i at [i*DATA_WIDTH +: DATA_WIDTH]
//   WrittenMask  out  NUM_REGS             bit i set: register i written since reset
//   WrCount      out  ADDR_WIDTH+1         number of distinct registers written
//
// There is no read bypass: a write becomes visible on RegsOut only after the
// clock edge that accepts it. Every output comes straight from a flop.
// ---------------------------------------------------------------------------
module register_bank #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int ZERO_REG   = 1
) (
    input  logic                           Clk,
    input  logic                           Reset,
    input  logic                           WrEn,
    input  logic [ADDR_WIDTH-1:0]          WrAddr,
    input  logic [DATA_WIDTH-1:0]          WrData,
    output logic [NUM_REGS*DATA_WIDTH-1:0] RegsOut,
    output logic [NUM_REGS-1:0]            WrittenMask,
    output logic [ADDR_WIDTH:0]            WrCount
);

    // Highest reachable count: register 0 never counts when hardwired to zero.
    localparam int                  CNT_MAX_I = NUM_REGS - ((ZERO_REG != 0) ? 1 : 0);
    localparam logic [ADDR_WIDTH:0] CNT_MAX   = CNT_MAX_I[ADDR_WIDTH:0];

    logic [NUM_REGS-1:0]   wr_sel;
    logic                  new_hit;
    logic [NUM_REGS-1:0]   mask_q, mask_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;

    function automatic logic [ADDR_WIDTH:0] sat_inc(input logic [ADDR_WIDTH:0] v,
                                                    input logic inc);
        if (inc && (v < CNT_MAX)) begin
            return v + (ADDR_WIDTH+1)'(1);
        end
        return v;
    endfunction

    // One-hot write decode gated by WrEn; the hardwired zero register is
    // never selected, so it also never reaches the mask or the count.
    always_comb begin
        wr_sel = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (WrEn && (WrAddr == ADDR_WIDTH'(i)) && !((ZERO_REG != 0) && (i == 0))) begin
                wr_sel[i] = 1'b1;
            end
        end
    end

    // A write only counts when it lands on a register not yet marked.
    always_comb begin
        new_hit = |(wr_sel & ~mask_q);
        mask_d  = mask_q | wr_sel;
        count_d = sat_inc(count_q, new_hit);
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            mask_q  <= '0;
            count_q <= '0;
        end else begin
            mask_q  <= mask_d;
            count_q <= count_d;
        end
    end

    assign WrittenMask = mask_q;
    assign WrCount     = count_q;

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg
        if ((ZERO_REG != 0) && (g == 0)) begin : g_zero
            assign RegsOut[g*DATA_WIDTH +: DATA_WIDTH] = '0;
        end else begin : g_store
            logic [DATA_WIDTH-1:0] reg_q, reg_d;

            always_comb begin
                reg_d = wr_sel[g] ? WrData : reg_q;
            end

            always_ff @(posedge Clk) begin
                if (!Reset) begin
                    reg_q <= '0;
                end else begin
                    reg_q <= reg_d;
                end
            end

            assign RegsOut[g*DATA_WIDTH +: DATA_WIDTH] = reg_q;
        end
    end

endmodule

// File: tb/tb_register_bank.sv
// ---------------------------------------------------------------------------
// tb_register_bank
//   Directed and randomized stimulus for register_bank, checked against a
//   behavioural model: an array of register values plus a written-flag mask,
//   with the count taken as the population count of that mask.
// ---------------------------------------------------------------------------
module tb_register_bank;

    localparam int DW = 32;
    localparam int NR = 32;
    localparam int AW = 5;

    logic             Clk = 1'b0;
    logic             Reset;
    logic             WrEn;
    logic [AW-1:0]    WrAddr;
    logic [DW-1:0]    WrData;
    logic [NR*DW-1:0] RegsOut;
    logic [NR-1:0]    WrittenMask;
    logic [AW:0]      WrCount;

    int n_checks = 0;
    int n_fails  = 0;

    logic [DW-1:0] m_regs [NR];
    logic [NR-1:0] m_mask;

    register_bank #(
        .DATA_WIDTH(DW),
        .NUM_REGS  (NR),
        .ADDR_WIDTH(AW),
        .ZERO_REG  (1)
    ) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .WrEn       (WrEn),
        .WrAddr     (WrAddr),
        .WrData     (WrData),
        .RegsOut    (RegsOut),
        .WrittenMask(WrittenMask),
        .WrCount    (WrCount)
    );

    always #5 Clk = ~Clk;

    function automatic logic [NR*DW-1:0] model_vec();
        logic [NR*DW-1:0] v;
        for (int i = 0; i < NR; i++) v[i*DW +: DW] = m_regs[i];
        return v;
    endfunction

    function automatic logic [AW:0] model_count();
        return (AW+1)'($countones(m_mask));
    endfunction

    function automatic logic [DW-1:0] mux_read(input logic [AW-1:0] sel);
        return RegsOut[sel*DW +: DW];
    endfunction

    task automatic model_clear();
        for (int i = 0; i < NR; i++) m_regs[i] = '0;
        m_mask = '0;
    endtask

    task automatic chk_vec(input string tag, input logic [NR*DW-1:0] obs,
                           input logic [NR*DW-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: RegsOut differs, first diff reg %0d observed %h expected %h",
                   tag, first_diff(obs, exp), obs[first_diff(obs, exp)*DW +: DW],
                   exp[first_diff(obs, exp)*DW +: DW]);
        end
    endtask

    function automatic int first_diff(input logic [NR*DW-1:0] a, input logic [NR*DW-1:0] b);
        for (int i = 0; i < NR; i++) if (a[i*DW +: DW] !== b[i*DW +: DW]) return i;
        return 0;
    endfunction

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk_vec({tag, ".regs"}, RegsOut, model_vec());
        chk32({tag, ".mask"}, WrittenMask, m_mask);
        chk32({tag, ".count"}, 32'(WrCount), 32'(model_count()));
    endtask

    // Drive one cycle of inputs at the falling edge, confirm nothing changes
    // before the rising edge, then advance the model and compare.
    task automatic step(input logic rst, input logic en, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input bit pre);
        @(negedge Clk);
        Reset  = rst;
        WrEn   = en;
        WrAddr = a;
        WrData = d;
        #1;
        if (pre) chk_vec("no_bypass", RegsOut, model_vec());
        @(posedge Clk);
        if (!rst) begin
            model_clear();
        end else if (en && (a != 0)) begin
            m_regs[a] = d;
            m_mask[a] = 1'b1;
        end
        #1;
    endtask

    initial begin
        Reset  = 1'b0;
        WrEn   = 1'b0;
        WrAddr = '0;
        WrData = '0;
        model_clear();

        // Reset held two cycles with a write pending
        step(1'b0, 1'b1, 5'd5, 32'hFFFF_FFFF, 1'b0);
        step(1'b0, 1'b1, 5'd5, 32'hFFFF_FFFF, 1'b0);
        check_all("reset");
        chk32("reset.slice5", mux_read(5'd5), 32'h0);

        // Single write
        step(1'b1, 1'b1, 5'd7, 32'hDEAD_BEEF, 1'b1);
        check_all("single");
        chk32("single.slice7", mux_read(5'd7), 32'hDEAD_BEEF);
        chk32("single.mask", WrittenMask, 32'h0000_0080);
        chk32("single.count", 32'(WrCount), 32'd1);

        // Write to the hardwired zero register
        step(1'b1, 1'b1, 5'd0, 32'h1234_5678, 1'b1);
        check_all("zero");
        chk32("zero.slice0", mux_read(5'd0), 32'h0);
        chk32("zero.count", 32'(WrCount), 32'd1);

        // Overwrite and distinct counting from a clean state
        step(1'b0, 1'b0, 5'd0, 32'h0, 1'b1);
        step(1'b1, 1'b1, 5'd3, 32'h1, 1'b1);
        step(1'b1, 1'b1, 5'd3, 32'h2, 1'b1);
        step(1'b1, 1'b1, 5'd31, 32'hA5A5_A5A5, 1'b1);
        check_all("overwrite");
        chk32("overwrite.slice3", mux_read(5'd3), 32'h2);
        chk32("overwrite.slice31", mux_read(5'd31), 32'hA5A5_A5A5);
        chk32("overwrite.mask", WrittenMask, 32'h8000_0008);
        chk32("overwrite.count", 32'(WrCount), 32'd2);

        // Fill every register back to back, then rewrite: count saturates
        step(1'b0, 1'b0, 5'd0, 32'h0, 1'b1);
        for (int i = 1; i < NR; i++) step(1'b1, 1'b1, AW'(i), 32'(i), 1'b1);
        check_all("fill");
        chk32("fill.mask", WrittenMask, 32'hFFFF_FFFE);
        chk32("fill.count", 32'(WrCount), 32'd31);
        for (int i = 0; i < 20; i++) step(1'b1, 1'b1, AW'($urandom_range(0, NR-1)), $urandom, 1'b1);
        check_all("rewrite");
        chk32("rewrite.count", 32'(WrCount), 32'd31);

        // Reset wins over a same-cycle write
        step(1'b0, 1'b1, 5'd9, $urandom | 32'h1, 1'b1);
        check_all("rst_vs_wr");
        chk32("rst_vs_wr.mask", WrittenMask, 32'h0);
        chk32("rst_vs_wr.port_a", mux_read(5'd9), 32'h0);
        chk32("rst_vs_wr.port_b", mux_read(5'd31), 32'h0);

        // First write after reset lands normally
        step(1'b1, 1'b1, 5'd9, 32'h0BAD_F00D, 1'b1);
        check_all("post_rst");

        // Random traffic with idle cycles and occasional resets
        for (int i = 0; i < 300; i++) begin
            step(($urandom_range(0, 24) != 0), ($urandom_range(0, 3) != 0),
                 AW'($urandom_range(0, NR-1)), $urandom, 1'b1);
            check_all("random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
